cs_loader: RTL and testbench

//  Boot-time control-store loader. Copies every word of the microcode EPROM into the

---
 rtl/cs_loader.sv | 168 ++++++++++++++++
 tb/tb_cs_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_loader.sv
// Boot-time control-store loader: copies every EPROM word into the microcode RAM, then raises cs_ready.
// Optional read-back verify pass is compiled in by defining CS_VERIFY_EN.
module cs_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram__w,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  cs_ready,
  output logic                  busy,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int LAT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WRITE   = 3'd1,
    S_RECOVER = 3'd2,
    S_DONE    = 3'd3,
    S_VFETCH  = 3'd4,
    S_VCHECK  = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

`ifdef CS_VERIFY_EN
  localparam state_t COPY_END = S_VFETCH;
`else
  localparam state_t COPY_END = S_DONE;
`endif

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [LAT_W-1:0]      lat_r, lat_s;
  logic [DATA_WIDTH-1:0] data_r, data_s;
  logic                  ram_w_r, ram_w_s;
  logic                  ready_r, ready_s;
  logic                  busy_r, busy_s;
  logic                  verr_r, verr_s;
  logic [ADDR_WIDTH-1:0] eaddr_r, eaddr_s;
  logic                  lat_last_s;
  logic                  addr_last_s;

  assign lat_last_s  = (lat_r == LAT_LAST);
  // Terminal count is checked before incrementing, so the counter never wraps mid-pass.
  assign addr_last_s = &addr_r;

`ifdef CS_VERIFY_EN
  logic mismatch_s;
  assign mismatch_s = (ram_rd_data != data_r);
`else
  logic unused_rd_data_s;
  assign unused_rd_data_s = ^ram_rd_data;
`endif

  assign rom_addr   = addr_r;
  assign ram_addr   = addr_r;
  assign ram_data   = data_r;
  assign ram__w     = ram_w_r;
  assign cs_ready   = ready_r;
  assign busy       = busy_r;
  assign verify_err = verr_r;
  assign err_addr   = eaddr_r;

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_r <= S_FETCH;
      addr_r  <= '0;
      lat_r   <= '0;
      data_r  <= '0;
      ram_w_r <= 1'b1;
      ready_r <= 1'b0;
      busy_r  <= 1'b1;
      verr_r  <= 1'b0;
      eaddr_r <= '0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      lat_r   <= lat_s;
      data_r  <= data_s;
      ram_w_r <= ram_w_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      verr_r  <= verr_s;
      eaddr_r <= eaddr_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_FETCH:   state_s = lat_last_s ? S_WRITE : S_FETCH;
      S_WRITE:   state_s = S_RECOVER;
      S_RECOVER: state_s = addr_last_s ? COPY_END : S_FETCH;
      S_DONE:    state_s = reload ? S_FETCH : S_DONE;
`ifdef CS_VERIFY_EN
      S_VFETCH:  state_s = lat_last_s ? S_VCHECK : S_VFETCH;
      S_VCHECK: begin
        if (mismatch_s) begin
          state_s = S_FAIL;
        end else if (addr_last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_VFETCH;
        end
      end
      S_FAIL:    state_s = S_FAIL;
`endif
      default:   state_s = S_FETCH;
    endcase
  end

  // Next values of the datapath and of the registered strobes, decoded from the next state.
  always_comb begin
    addr_s  = addr_r;
    lat_s   = lat_r;
    data_s  = data_r;
    verr_s  = verr_r;
    eaddr_s = eaddr_r;
    ram_w_s = (state_s != S_WRITE);
    ready_s = (state_s == S_DONE);
    busy_s  = (state_s != S_DONE) && (state_s != S_FAIL);
    case (state_r)
      S_FETCH, S_VFETCH: begin
        if (lat_last_s) begin
          lat_s  = '0;
          data_s = rom_data;
        end else begin
          lat_s  = lat_r + 1'b1;
        end
      end
      S_RECOVER: begin
        if (addr_last_s) begin
          addr_s = '0;
        end else begin
          addr_s = addr_r + 1'b1;
        end
      end
`ifdef CS_VERIFY_EN
      S_VCHECK: begin
        if (mismatch_s) begin
          verr_s  = 1'b1;
          eaddr_s = addr_r;
        end else if (addr_last_s) begin
          addr_s  = '0;
        end else begin
          addr_s  = addr_r + 1'b1;
        end
      end
`endif
      S_DONE:  addr_s = '0;
      default: addr_s = addr_r;
    endcase
  end

endmodule

// File: tb/tb_cs_loader.sv
// Randomized self-checking bench for cs_loader: a ROM_LATENCY=1 and a ROM_LATENCY=3 instance
// run against latency-aware ROM and RAM models; expectations follow CS_VERIFY_EN when defined.
`timescale 1ns/1ps
module tb_cs_loader;

  localparam int AW = 8;
  localparam int DW = 64;
  localparam int N  = 256;

  logic          clk = 1'b0;
  logic          _reset;
  logic [1:0]    reload;
  logic [1:0]    fault_en;
  logic [AW-1:0] rom_addr_v [2];
  logic [DW-1:0] ram_data_v [2];
  logic [AW-1:0] err_addr_v [2];
  logic [1:0]    ram_w_v, ready_v, busy_v, verr_v;

  logic [DW-1:0] rom_mem [N];
  logic [DW-1:0] ram_mem [2][N];
  int            wr_cnt [2];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] rom_data, ram_rd_data;
    logic [AW-1:0] seen_addr = '1;
    int            age = 0;
    logic          w_prev = 1'b1;
    logic          busy_prev = 1'b1;

    cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(L)) dut (
      .clk(clk), ._reset(_reset), .reload(reload[g]),
      .rom_addr(rom_addr_v[g]), .rom_data(rom_data),
      .ram_addr(ram_addr), .ram_data(ram_data_v[g]), .ram__w(ram_w_v[g]),
      .ram_rd_data(ram_rd_data), .cs_ready(ready_v[g]), .busy(busy_v[g]),
      .verify_err(verr_v[g]), .err_addr(err_addr_v[g])
    );

    // ROM: data is valid only once the address has been stable for L cycles; stale reads return garbage.
    always @(negedge clk) begin
      if (rom_addr_v[g] != seen_addr) begin
        seen_addr <= rom_addr_v[g];
        age       <= 0;
      end else if (age < 1000) begin
        age <= age + 1;
      end
    end
    assign rom_data = ((rom_addr_v[g] == seen_addr) && (age >= L - 1)) ?
                      rom_mem[rom_addr_v[g]] : ~rom_mem[rom_addr_v[g]];

`ifdef CS_VERIFY_EN
    assign ram_rd_data = ram_mem[g][ram_addr] ^ ((fault_en[g] && ram_addr == 8'h42) ? 64'h20 : 64'h0);
`else
    // Deliberately wrong read data: the default build must ignore it.
    assign ram_rd_data = ~ram_mem[g][ram_addr];
`endif

    // Write monitor / RAM model: writes must arrive in address order, one cycle wide, with ROM data.
    always @(negedge clk) begin
      if (!_reset || (busy_v[g] && !busy_prev)) begin
        wr_cnt[g] = 0;
        for (int i = 0; i < N; i++) ram_mem[g][i] = '0;
      end
      if (_reset && !ram_w_v[g]) begin
        check("wr_addr", ram_addr, wr_cnt[g]);
        check("wr_addr_eq", ram_addr, rom_addr_v[g]);
        check("wr_data", ram_data_v[g], rom_mem[ram_addr]);
        check("wr_width", w_prev, 1);
        ram_mem[g][ram_addr] = ram_data_v[g];
        wr_cnt[g]++;
      end
      check("ready_busy_excl", ready_v[g] & busy_v[g], 0);
`ifndef CS_VERIFY_EN
      check("verr_const", {verr_v[g], err_addr_v[g]}, 0);
`endif
      w_prev    = ram_w_v[g];
      busy_prev = busy_v[g];
    end
  end

  function automatic int exp_lat(input int g);
    int l;
    l = (g == 0) ? 1 : 3;
`ifdef CS_VERIFY_EN
    return N * (l + 2) + N * (l + 1);
`else
    return N * (l + 2);
`endif
  endfunction

  task automatic check_reset_state(input int g);
    check("rst_addr", rom_addr_v[g], 0);
    check("rst_ram_w", ram_w_v[g], 1);
    check("rst_ready", ready_v[g], 0);
    check("rst_busy", busy_v[g], 1);
    check("rst_data", ram_data_v[g], 0);
    check("rst_verr", verr_v[g], 0);
    check("rst_eaddr", err_addr_v[g], 0);
  endtask

  task automatic check_ram(input int g);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) if (ram_mem[g][i] !== rom_mem[i]) bad++;
    check("ram_eq_rom", bad, 0);
    check("wr_count", wr_cnt[g], N);
    check("done_verr", verr_v[g], 0);
    check("done_addr", rom_addr_v[g], 0);
    check("done_busy", busy_v[g], 0);
  endtask

  // Runs until every instance in mask shows cs_ready, checking the rise cycle against t0.
  task automatic run_until_ready(input int t0, input logic [1:0] mask, input int pulse_at);
    logic [1:0] seen;
    seen = 2'b00;
    for (int c = 0; c < 6000 && ((mask & ~seen) != 2'b00); c++) begin
      reload[0] = (c == pulse_at);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (mask[g] && !seen[g] && ready_v[g]) begin
          seen[g] = 1'b1;
          check("ready_latency", cyc - t0, exp_lat(g));
        end
      end
    end
    reload = 2'b00;
    for (int g = 0; g < 2; g++) if (mask[g] && !seen[g]) check("ready_timeout", 0, 1);
  endtask

  initial begin
    int   t0;
    logic found;
    _reset   = 1'b0;
    reload   = 2'b00;
    fault_en = 2'b00;
    for (int i = 0; i < N; i++) rom_mem[i] = {8{8'(i)}};
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);

    // Full copy; a reload pulse while busy must be ignored.
    _reset = 1'b1;
    t0 = cyc;
    run_until_ready(t0, 2'b11, 299);
    check_ram(0);
    check_ram(1);

    // Reload from DONE restarts instance 0 only.
    reload[0] = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    reload[0] = 1'b0;
    check("reload_ready", ready_v[0], 0);
    check("reload_busy", busy_v[0], 1);
    check("reload_addr", rom_addr_v[0], 0);
    check("other_ready", ready_v[1], 1);
    run_until_ready(t0, 2'b01, -1);
    check_ram(0);

    // Random ROM image, then reset in the middle of the write of address 0x64.
    _reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) rom_mem[i] = {$urandom, $urandom};
    _reset = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (!ram_w_v[0] && rom_addr_v[0] == 8'h64) found = 1'b1;
    end
    check("hit_write_64", found, 1);
    _reset = 1'b0;
    @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    _reset = 1'b1;
    t0 = cyc;
    run_until_ready(t0, 2'b11, -1);
    check_ram(0);
    check_ram(1);

`ifdef CS_VERIFY_EN
    // Corrupted read-back at 0x42 must end in FAIL, which only reset leaves.
    _reset   = 1'b0;
    fault_en = 2'b01;
    repeat (2) @(negedge clk);
    _reset = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(negedge clk);
      if (!busy_v[0]) found = 1'b1;
    end
    check("fail_reached", found, 1);
    check("fail_verr", verr_v[0], 1);
    check("fail_eaddr", err_addr_v[0], 8'h42);
    check("fail_ready", ready_v[0], 0);
    reload[0] = 1'b1;
    @(negedge clk);
    reload[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("fail_hold_busy", busy_v[0], 0);
    check("fail_hold_ready", ready_v[0], 0);
    check("fail_hold_verr", verr_v[0], 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
